// File: rtl/bus_slave_regbank.sv
// bus_slave_regbank: responder for the two-phase sel/enable bus.
// Decodes a window of DEPTH word addresses starting at BASE_ADDR and backs it
// with a register bank. An optional wait-state count delays the access. The
// transfer finishes with a one-cycle ready pulse; err flags an access outside
// the window.
module bus_slave_regbank #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slave_sel,
  input  logic              slave_enable,
  input  logic              slave_wr_dir,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic [DATA_W-1:0] slave_rdata,
  output logic              slave_ready,
  output logic              slave_err
);

  localparam logic [7:0]    WS8   = 8'(WAIT_STATES);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_RESP} state_t;

  state_t              state, nxt;
  logic [7:0]          cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_wr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic                capture, load_cnt, dec_cnt, access;
  logic [ADDR_W-1:0]   offset;
  logic                hit;
  logic [DATA_W-1:0]   rd_val;

  // Decode of the latched address; the mux yields zero when nothing matches.
  always_comb begin
    offset = lat_addr - BASE_ADDR;
    hit    = (lat_addr >= BASE_ADDR) && ({1'b0, offset} < DEPTH_X);
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++)
      if (offset == ADDR_W'(i)) rd_val = regs[i];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    nxt      = state;
    capture  = 1'b0;
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    access   = 1'b0;
    case (state)
      S_IDLE: begin
        // sel&en without a setup phase is not a transfer.
        if (slave_sel && !slave_enable) begin
          capture = 1'b1;
          nxt     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (slave_sel && slave_enable) begin
          if (WS8 == 8'd0) begin
            access = 1'b1;
            nxt    = S_RESP;
          end else begin
            load_cnt = 1'b1;
            nxt      = S_WAIT;
          end
        end else if (slave_sel) begin
          capture = 1'b1;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!(slave_sel && slave_enable)) begin
          nxt = S_IDLE;
        end else if (cnt == 8'd1) begin
          access = 1'b1;
          nxt    = S_RESP;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      S_RESP: begin
        if (slave_sel && !slave_enable) begin
          capture = 1'b1;
          nxt     = S_SETUP;
        end else begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      lat_addr    <= '0;
      lat_wr      <= 1'b0;
      lat_wdata   <= '0;
      slave_rdata <= '0;
      slave_ready <= 1'b0;
      slave_err   <= 1'b0;
    end else begin
      slave_ready <= access;
      slave_err   <= access && !hit;
      if (capture) begin
        lat_addr  <= slave_addr;
        lat_wr    <= slave_wr_dir;
        lat_wdata <= slave_wdata;
      end
      if (load_cnt)     cnt <= WS8;
      else if (dec_cnt) cnt <= cnt - 8'd1;
      // rd_val is already zero on a miss.
      if (access && !lat_wr) slave_rdata <= rd_val;
    end
  end

  // Register bank write; a miss matches no entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (access && lat_wr && hit) begin
      for (int i = 0; i < DEPTH; i++)
        if (offset == ADDR_W'(i)) regs[i] <= lat_wdata;
    end
  end

endmodule

// File: doc/bus_slave_regbank.md
Name: bus_slave_regbank

Overview:
Bus responder endpoint for the two-phase sel/enable master protocol routed by nic_top. It decodes a window of word addresses, holds a bank of DEPTH registers, and inserts a configurable number of wait states. It returns read data with a one-cycle ready/err response pulse. It sits on a nic_top slave port and serves as the far end of every master read or write to its window.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data / register width
BASE_ADDR, 16'h0000, first word address of the window
DEPTH, 16, number of registers; window is BASE_ADDR .. BASE_ADDR+DEPTH-1
WAIT_STATES, 0, extra cycles inserted between enable sampled and access (0..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on clk rising edge)
slave_sel  input  1  transaction select
slave_enable  input  1  access phase strobe
slave_wr_dir  input  1  1 = write, 0 = read
slave_addr  input  ADDR_W  word address
slave_wdata  input  DATA_W  write data
slave_rdata  output  DATA_W  read data, registered
slave_ready  output  1  one-cycle transfer-complete pulse, registered
slave_err  output  1  one-cycle out-of-window flag, valid with slave_ready

Behaviour:
- Reset (rst==0 at an edge):
  - all registers, slave_rdata, slave_ready, slave_err and the wait counter go to 0; state goes to IDLE.
  - Reset wins over any transaction in flight; a pending write is discarded.
- Decode: hit = (addr >= BASE_ADDR) && (addr - BASE_ADDR < DEPTH); index = addr - BASE_ADDR. Word addressing, no byte lanes.
- Capture: addr, wr_dir and wdata are latched on the setup edge (sel=1, en=0). Input changes during the access phase are ignored.
- States:
  - IDLE: sel&!en -> capture, SETUP. sel&en (no setup phase) -> ignored, stay IDLE. Otherwise stay.
  - SETUP:
    - sel&en with WAIT_STATES==0 -> perform access, go RESP.
    - sel&en with WAIT_STATES>0 -> cnt<=WAIT_STATES, go WAIT.
    - sel&!en -> re-capture, stay SETUP.
    - !sel -> IDLE, no side effect.
  - WAIT: !(sel&en) -> abort to IDLE (no write, no ready). cnt==1 -> perform access, go RESP. Else cnt<=cnt-1.
  - RESP: slave_ready=1 and slave_err valid this cycle only. Next edge clears both. sel&!en -> capture, SETUP (back-to-back). Else -> IDLE.
- Access on a hit:
  - write: reg[index] <= latched wdata.
  - read: slave_rdata <= reg[index].
- Access on a miss:
  - slave_err<=1.
  - write: no register changes.
  - read: slave_rdata <= 0.
- Latency:
  - Read data and ready are visible in the cycle after the access edge.
  - With WAIT_STATES=N, slave_ready rises after the (N+1)th edge at which sel&en is sampled high.
- slave_rdata holds its last read value across writes, idle cycles and aborts. It changes only on a completed read or on reset.
- The master may drop sel/en at or after ready; holding them beyond RESP does not start a new transfer without a fresh setup phase.

Test Plan:
1. Hold rst=0 for 2 cycles with random bus inputs -> slave_rdata=0, slave_ready=0, slave_err=0, and a subsequent read of every address in the window returns 0x0000.
2. WAIT_STATES=0, BASE=0: write 0xABCD to 0x0002, then read 0x0002 -> slave_rdata=0xABCD one cycle after the enable edge, slave_ready high exactly one cycle per transfer, slave_err=0.
3. WAIT_STATES=2: write 0x1234 to 0x0005 holding sel/en -> slave_ready rises after the 3rd enable-high edge. A read of 0x0005 then returns 0x1234 with the same latency.
4. DEPTH=16: write 0x5555 to 0x0010 -> slave_ready=1, slave_err=1, and reg[0..15] are unchanged. Read 0x0010 -> slave_rdata=0x0000, slave_err=1.
5. WAIT_STATES=3: write 0xBEEF to 0x0001 and drop sel during WAIT -> no slave_ready pulse. A read of 0x0001 returns the prior value 0x0000.
6. WAIT_STATES=3: write 0x7777 to 0x0003 and assert rst=0 during WAIT -> state IDLE, outputs 0. After release, a read of 0x0003 returns 0x0000.
